// File: rtl/updn_counter_n_if.sv
// rtl/updn_counter_n_if.sv - control and status bundle for the up/down counter
interface updn_counter_n_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             udbar;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] limit;
   logic             clr_ovf;
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             wrap;
   logic             ovf;

   modport master (
      output en, udbar, load, load_val, limit, clr_ovf,
      input  cnt, tc, wrap, ovf
   );

   modport slave (
      input  en, udbar, load, load_val, limit, clr_ovf,
      output cnt, tc, wrap, ovf
   );
endinterface

// File: rtl/updn_counter_n.sv
// rtl/updn_counter_n.sv - loadable up/down counter with runtime limit, wrap/saturate and event flags
module updn_counter_n #(
   parameter int WIDTH    = 4,
   parameter int SAT_MODE = 0
) (
   input logic            clk,
   input logic            rst,
   updn_counter_n_if.slave bus
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_next;
   logic             wrap_q;
   logic             ovf_q;
   logic             up_bnd;
   logic             dn_bnd;
   logic             lim_zero;
   logic             bnd_evt;

   // Boundary conditions; up uses >= so a limit lowered below cnt behaves as the terminal value
   always_comb begin
      up_bnd   = bus.udbar && (cnt_q >= bus.limit);
      dn_bnd   = !bus.udbar && (cnt_q == '0);
      lim_zero = (bus.limit == '0);
      // limit == 0 makes every enabled count an event, even a down count from a stale nonzero cnt
      bnd_evt  = bus.en && !bus.load && (up_bnd || dn_bnd || lim_zero);
   end

   // Next count: load clamps to limit, otherwise step, wrap or saturate
   always_comb begin
      cnt_next = cnt_q;
      if (bus.load) begin
         cnt_next = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      end else if (bus.en) begin
         if (lim_zero) begin
            cnt_next = '0;
         end else if (bus.udbar) begin
            if (up_bnd)
               cnt_next = (SAT_MODE != 0) ? cnt_q : '0;
            else
               cnt_next = cnt_q + 1'b1;
         end else begin
            if (dn_bnd)
               cnt_next = (SAT_MODE != 0) ? '0 : bus.limit;
            else
               cnt_next = cnt_q - 1'b1;
         end
      end
   end

   // State registers; ovf set takes priority over a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_next;
         wrap_q <= bnd_evt;
         if (bnd_evt)
            ovf_q <= 1'b1;
         else if (bus.clr_ovf)
            ovf_q <= 1'b0;
      end
   end

   assign bus.cnt  = cnt_q;
   assign bus.wrap = wrap_q;
   assign bus.ovf  = ovf_q;
   assign bus.tc   = bus.en && !bus.load && (up_bnd || dn_bnd);

endmodule

// File: tb/tb_updn_counter_n.sv
// tb/tb_updn_counter_n.sv - directed checks of wrap and saturate counter instances
module tb_updn_counter_n;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       udbar;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] limit;
   logic       clr_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   updn_counter_n_if #(.WIDTH(4)) ia ();
   updn_counter_n_if #(.WIDTH(4)) ib ();

   assign ia.en = en;       assign ib.en = en;
   assign ia.udbar = udbar; assign ib.udbar = udbar;
   assign ia.load = load;   assign ib.load = load;
   assign ia.load_val = load_val; assign ib.load_val = load_val;
   assign ia.limit = limit; assign ib.limit = limit;
   assign ia.clr_ovf = clr_ovf; assign ib.clr_ovf = clr_ovf;

   updn_counter_n #(.WIDTH(4), .SAT_MODE(0)) dut_wrap (.clk(clk), .rst(rst), .bus(ia.slave));
   updn_counter_n #(.WIDTH(4), .SAT_MODE(1)) dut_sat  (.clk(clk), .rst(rst), .bus(ib.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string tag,
                             input int ca, input int wa, input int oa,
                             input int cb, input int wb, input int ob);
      check({tag, " cnt_a"},  32'(ia.cnt),  32'(ca));
      check({tag, " wrap_a"}, 32'(ia.wrap), 32'(wa));
      check({tag, " ovf_a"},  32'(ia.ovf),  32'(oa));
      check({tag, " cnt_b"},  32'(ib.cnt),  32'(cb));
      check({tag, " wrap_b"}, 32'(ib.wrap), 32'(wb));
      check({tag, " ovf_b"},  32'(ib.ovf),  32'(ob));
   endtask

   int exp_a [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int exp_b [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
   int dn_a  [4]  = '{1, 0, 15, 14};
   int dn_b  [4]  = '{1, 0, 0, 0};
   int dn_wa [4]  = '{0, 0, 1, 0};
   int dn_wb [4]  = '{0, 0, 1, 1};
   int dn_o  [4]  = '{0, 0, 1, 1};

   initial begin
      rst = 1'b1; en = 1'b0; udbar = 1'b1; load = 1'b0;
      load_val = 4'd0; limit = 4'd9; clr_ovf = 1'b0;
      step();
      check_both("reset", 0, 0, 0, 0, 0, 0);

      // tc stays combinational while held in reset
      en = 1'b1; udbar = 1'b1; #1;
      check("tc_rst_up", 32'(ia.tc), 32'd0);
      udbar = 1'b0; #1;
      check("tc_rst_dn", 32'(ia.tc), 32'd1);

      // Up count 0..9 and past the boundary
      rst = 1'b0; udbar = 1'b1; en = 1'b1; limit = 4'd9;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("tc_up", 32'(ia.tc), (i == 9) ? 32'd1 : 32'd0);
         step();
         check_both("up", exp_a[i], (i == 9) ? 1 : 0, (i >= 9) ? 1 : 0,
                    exp_b[i], (i >= 9) ? 1 : 0, (i >= 9) ? 1 : 0);
      end

      // Down count from 2 with limit 15
      rst = 1'b1; step(); rst = 1'b0;
      limit = 4'd15; load = 1'b1; load_val = 4'd2; en = 1'b1;
      step();
      check_both("load2", 2, 0, 0, 2, 0, 0);
      load = 1'b0; udbar = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_both("down", dn_a[i], dn_wa[i], dn_o[i], dn_b[i], dn_wb[i], dn_o[i]);
      end

      // Load clamps to limit and suppresses the event; ovf unchanged
      load = 1'b1; load_val = 4'd12; limit = 4'd9; udbar = 1'b1; #1;
      check("tc_load", 32'(ia.tc), 32'd0);
      step();
      check_both("load_clamp", 9, 0, 1, 9, 0, 1);
      load = 1'b0;
      step();
      check_both("after_clamp", 0, 1, 1, 9, 1, 1);

      // Set beats clear when they coincide
      load = 1'b1; load_val = 4'd9; step(); load = 1'b0;
      check_both("reload9", 9, 0, 1, 9, 0, 1);
      clr_ovf = 1'b1;
      step();
      check_both("clr_vs_set", 0, 1, 1, 9, 1, 1);
      en = 1'b0;
      step();
      check_both("clr_alone", 0, 0, 0, 9, 0, 0);
      clr_ovf = 1'b0;

      // Reset mid-count overrides load
      en = 1'b1; load = 1'b1; load_val = 4'd9; step();
      load = 1'b0; step();
      check_both("pre_rst_evt", 0, 1, 1, 9, 1, 1);
      load = 1'b1; load_val = 4'd5; step();
      check_both("load5", 5, 0, 1, 5, 0, 1);
      rst = 1'b1; load_val = 4'd3; step();
      check_both("rst_mid", 0, 0, 0, 0, 0, 0);
      rst = 1'b0; load = 1'b0; step();
      check_both("resume", 1, 0, 0, 1, 0, 0);

      // Full-range limit
      limit = 4'd15; load = 1'b1; load_val = 4'd15; step(); load = 1'b0;
      step();
      check_both("max_up", 0, 1, 1, 15, 1, 1);
      load = 1'b1; load_val = 4'd0; step(); load = 1'b0;
      udbar = 1'b0;
      step();
      check_both("max_dn", 15, 1, 1, 0, 1, 1);

      // Limit lowered below cnt
      clr_ovf = 1'b1; en = 1'b0; step(); clr_ovf = 1'b0; en = 1'b1;
      load = 1'b1; load_val = 4'd8; step(); load = 1'b0;
      limit = 4'd3; udbar = 1'b0;
      step();
      check_both("low_lim_dn", 7, 0, 0, 7, 0, 0);
      udbar = 1'b1;
      step();
      check_both("low_lim_up", 0, 1, 1, 7, 1, 1);

      // Limit zero forces cnt to 0 with an event on every enabled count
      clr_ovf = 1'b1; en = 1'b0; step(); clr_ovf = 1'b0;
      limit = 4'd15; load = 1'b1; load_val = 4'd5; step(); load = 1'b0;
      limit = 4'd0; en = 1'b1; udbar = 1'b0;
      step();
      check_both("lim0_a", 0, 1, 1, 0, 1, 1);
      udbar = 1'b1;
      step();
      check_both("lim0_b", 0, 1, 1, 0, 1, 1);
      en = 1'b0;
      step();
      check_both("hold", 0, 0, 1, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/updn_counter_n.md
UPDN_COUNTER_N -- requirements
Module: updn_counter_n

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal 2..32).
REQ-002 Parameter: SAT_MODE, default 0, boundary behaviour (0 = wrap, 1 = saturate).
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: en  input  1  count enable.
REQ-006 Port: udbar  input  1  direction (1 = up, 0 = down).
REQ-007 Port: load  input  1  parallel load strobe.
REQ-008 Port: load_val  input  WIDTH  parallel load value.
REQ-009 Port: limit  input  WIDTH  runtime terminal value; count range is 0..limit.
REQ-010 Port: clr_ovf  input  1  clears the ovf flag.
REQ-011 Port: cnt  output  WIDTH  registered count value.
REQ-012 Port: tc  output  1  combinational terminal-count indicator.
REQ-013 Port: wrap  output  1  registered one-cycle boundary-event pulse.
REQ-014 Port: ovf  output  1  registered sticky boundary-event flag.

Function
REQ-015 Priority per edge SHALL be: rst > load > en; with en=0 and load=0, cnt holds.
REQ-016 Load SHALL set cnt to min(load_val, limit) on the next edge, regardless of en and udbar.
REQ-017 A load SHALL NOT generate a boundary event; wrap is 0 the following cycle and ovf is unchanged.
REQ-018 Up count with cnt < limit SHALL set cnt to cnt+1.
REQ-019 Down count with cnt > 0 SHALL set cnt to cnt-1.
REQ-020 Up boundary (en=1, udbar=1, cnt >= limit) SHALL be a boundary event; the next cnt is 0 when SAT_MODE=0 and unchanged when SAT_MODE=1.
REQ-021 Down boundary (en=1, udbar=0, cnt == 0) SHALL be a boundary event; the next cnt is limit when SAT_MODE=0 and 0 when SAT_MODE=1.
REQ-022 Limit lowered below cnt while not loading:
  - up count: treated as the up boundary (REQ-020);
  - down count: decrements normally.
REQ-023 Limit = 0:
  - cnt is forced to 0 on any enabled count;
  - every enabled count is a boundary event.
REQ-024 tc SHALL equal en & ~load & ((udbar & cnt >= limit) | (~udbar & cnt == 0)), with zero latency.
REQ-025 wrap SHALL be 1 for exactly the one cycle following each boundary event, including in SAT_MODE=1.
REQ-026 wrap SHALL be asserted every cycle while boundary events repeat back-to-back, e.g. saturated with en held.
REQ-027 ovf SHALL set on the edge that registers a boundary event and stay set until cleared.
REQ-028 clr_ovf SHALL clear ovf on the next edge; if clr_ovf and a boundary event coincide, ovf SHALL be 1 (set wins).
REQ-029 All arithmetic SHALL be WIDTH-bit unsigned; no intermediate value may truncate incorrectly at limit = 2^WIDTH-1.
REQ-030 Direction changes SHALL take effect on the same edge; no pipeline stage exists between inputs and cnt.

Reset
REQ-031 On a rst=1 edge, outputs SHALL be: cnt=0, wrap=0, ovf=0; rst overrides load, en and clr_ovf.
REQ-032 Reset asserted mid-count SHALL take effect on that edge; counting resumes on the first edge with rst=0.
REQ-033 tc SHALL follow REQ-024 during reset, being combinational.

Verification
REQ-034 WIDTH=4, SAT_MODE=0, limit=9, up, en=1 from 0 for 12 cycles -> cnt 1..9,0,1,2; tc high while cnt=9; wrap pulse once, one cycle after cnt=9; ovf=1 thereafter.
REQ-035 WIDTH=4, SAT_MODE=1, limit=15, down from 2 for 4 cycles -> cnt 1,0,0,0; wrap high for the last two cycles; ovf=1.
REQ-036 load=1, load_val=12, limit=9, en=1 -> cnt=9 next edge; wrap=0; then one up count -> cnt=0 and wrap=1.
REQ-037 ovf=1 with clr_ovf=1 on the same edge as an up boundary -> ovf stays 1; clr_ovf alone on the next edge -> ovf=0.
REQ-038 Counting up at cnt=5, rst=1 for one edge with load=1 and load_val=3 -> cnt=0, wrap=0, ovf=0; count then resumes at 1.
REQ-039 limit=15 (max), SAT_MODE=0, up from 15 -> cnt=0 with wrap; down from 0 -> cnt=15 with wrap.
